// File: rtl/rc_accumulator_pkg.sv
// rtl/rc_accumulator_pkg.sv - shared widths and state encodings for the accumulator
//
// Purpose : Holds the adder width, the operand-count width and the two-bit
//           controller state encodings used by rc_accumulator.
// Ports   : none (package)
package rc_accumulator_pkg;

    localparam int RC_ADDR_BANDWITH = 4;
    localparam int RC_ACC_COUNT_W   = 4;

    typedef enum logic [1:0] {
        RC_ACC_IDLE = 2'b00,
        RC_ACC_ACC  = 2'b01,
        RC_ACC_DONE = 2'b10
    } rc_acc_state_e;

endpackage

// File: rtl/RC_Adder.sv
// rtl/RC_Adder.sv - combinational ripple-carry adder
//
// Purpose : WIDTH-bit ripple-carry adder built from a chain of full adders.
// Ports   : A, B  - operands
//           Sum   - A + B modulo 2^WIDTH
//           Cout  - carry out of the most significant bit
module RC_Adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign Sum[i]       = A[i] ^ B[i] ^ w_carry[i];
        assign w_carry[i+1] = (A[i] & B[i]) | (w_carry[i] & (A[i] ^ B[i]));
    end

    assign Cout = w_carry[WIDTH];

endmodule

// File: rtl/rc_accumulator.sv
// rtl/rc_accumulator.sv - streaming multi-operand accumulator around RC_Adder
//
// Purpose : After start, accepts num_ops operands over a valid/ready stream,
//           sums them modulo 2^WIDTH through RC_Adder (sum fed back as A),
//           keeps a sticky OR of every carry, then holds the result on a
//           valid/ready output until taken.
// Ports   : clk, rst_n          - clock, asynchronous active-low reset
//           start, num_ops      - run command and operand count (IDLE only)
//           in_valid/in_ready/in_data    - operand stream
//           out_valid/out_ready/out_sum/out_carry - result stream
//           busy                - high whenever not IDLE
module rc_accumulator
    import rc_accumulator_pkg::*;
#(
    parameter int WIDTH   = RC_ADDR_BANDWITH,
    parameter int COUNT_W = RC_ACC_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_ops,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic               out_carry,
    output logic               busy
);

    rc_acc_state_e      r_state;
    logic [WIDTH-1:0]   r_acc;
    logic               r_sticky;
    logic [COUNT_W-1:0] r_remaining;

    rc_acc_state_e      w_state_nxt;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic               w_sticky_nxt;
    logic [COUNT_W-1:0] w_remaining_nxt;

    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_done;

    RC_Adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .A    (r_acc),
        .B    (in_data),
        .Sum  (w_sum),
        .Cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RC_ACC_IDLE;
            r_acc       <= '0;
            r_sticky    <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_sticky    <= w_sticky_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_sticky_nxt    = r_sticky;
        w_remaining_nxt = r_remaining;
        case (r_state)
            RC_ACC_IDLE: begin
                if (start) begin
                    w_acc_nxt    = '0;
                    w_sticky_nxt = 1'b0;
                    // A zero-length run skips ACC and reports an empty sum.
                    if (num_ops != '0) begin
                        w_remaining_nxt = num_ops;
                        w_state_nxt     = RC_ACC_ACC;
                    end else begin
                        w_state_nxt     = RC_ACC_DONE;
                    end
                end
            end
            RC_ACC_ACC: begin
                // in_ready is constant high here, so in_valid alone is the handshake.
                if (in_valid) begin
                    w_acc_nxt       = w_sum;
                    w_sticky_nxt    = r_sticky | w_cout;
                    w_remaining_nxt = r_remaining - COUNT_W'(1);
                    if (r_remaining == COUNT_W'(1)) begin
                        w_state_nxt = RC_ACC_DONE;
                    end
                end
            end
            RC_ACC_DONE: begin
                if (out_ready) begin
                    w_state_nxt = RC_ACC_IDLE;
                end
            end
            default: begin
                w_state_nxt = RC_ACC_IDLE;
            end
        endcase
    end

    // All outputs decode from registers only; the result is masked outside DONE.
    assign w_done    = (r_state == RC_ACC_DONE);
    assign in_ready  = (r_state == RC_ACC_ACC);
    assign out_valid = w_done;
    assign busy      = (r_state != RC_ACC_IDLE);
    assign out_sum   = w_done ? r_acc : '0;
    assign out_carry = w_done & r_sticky;

endmodule

// File: tb/tb_rc_accumulator.sv
// tb/tb_rc_accumulator.sv - directed self-checking bench for rc_accumulator
module tb_rc_accumulator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] num_ops;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic       out_carry;
    logic       busy;

    int n_checks;
    int n_errors;

    rc_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_ops   (num_ops),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [3:0] n);
        start   = 1'b1;
        num_ops = n;
        step();
        start   = 1'b0;
        num_ops = 4'd0;
    endtask

    task automatic feed(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        in_data  = 4'd0;
    endtask

    task automatic finish_run(input string tag, input logic [3:0] exp_sum, input logic exp_carry);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"},   32'(out_sum),   32'(exp_sum));
        chk({tag, "_carry"}, 32'(out_carry), 32'(exp_carry));
        chk({tag, "_inrdy"}, 32'(in_ready),  32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_idle_busy"},  32'(busy),      32'd0);
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    logic [3:0] pat_valid;
    logic [3:0] pat_data [4];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        num_ops   = 4'd0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_inrdy", 32'(in_ready),  32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",   32'(out_sum),   32'd0);
        chk("rst_carry", 32'(out_carry), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        rst_n = 1'b1;
        step();

        // 2 + 2 + 6 = 10, no carry
        start_run(4'd3);
        chk("t1_inrdy", 32'(in_ready), 32'd1);
        chk("t1_busy",  32'(busy),     32'd1);
        feed(4'd2);
        feed(4'd2);
        feed(4'd6);
        finish_run("t1", 4'd10, 1'b0);

        // 15 + 1 wraps to 0 with carry, + 3 = 3; sticky survives
        start_run(4'd3);
        feed(4'd15);
        feed(4'd1);
        feed(4'd3);
        finish_run("t2", 4'd3, 1'b1);

        // sticky cleared by the next start
        start_run(4'd1);
        feed(4'd7);
        finish_run("t2b", 4'd7, 1'b0);

        // zero operands: result the cycle after start, in_ready never high
        chk("t3_pre_inrdy", 32'(in_ready), 32'd0);
        start_run(4'd0);
        finish_run("t3", 4'd0, 1'b0);

        // gaps in in_valid: only the two valid beats (5 and 3) count
        pat_valid   = 4'b1001;
        pat_data[0] = 4'd5;
        pat_data[1] = 4'd9;
        pat_data[2] = 4'd9;
        pat_data[3] = 4'd3;
        start_run(4'd2);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_inrdy%0d", i), 32'(in_ready), 32'd1);
            in_valid = pat_valid[i];
            in_data  = pat_data[i];
            step();
        end
        in_valid = 1'b0;
        in_data  = 4'd0;
        finish_run("t4", 4'd8, 1'b0);

        // DONE holds for 5 cycles with a start pulse that must be ignored
        start_run(4'd2);
        feed(4'd12);
        feed(4'd7);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t5_hold_valid%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("t5_hold_sum%0d", i),   32'(out_sum),   32'd3);
            chk($sformatf("t5_hold_carry%0d", i), 32'(out_carry), 32'd1);
            start   = (i == 2);
            num_ops = (i == 2) ? 4'd5 : 4'd0;
            step();
        end
        start   = 1'b0;
        num_ops = 4'd0;
        finish_run("t5", 4'd3, 1'b1);
        chk("t5_after_inrdy", 32'(in_ready), 32'd0);

        // asynchronous reset mid-run
        start_run(4'd4);
        feed(4'd3);
        feed(4'd4);
        chk("t6_busy_pre", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_busy",  32'(busy),      32'd0);
        chk("t6_async_inrdy", 32'(in_ready),  32'd0);
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_sum",   32'(out_sum),   32'd0);
        chk("t6_async_carry", 32'(out_carry), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_idle_busy", 32'(busy), 32'd0);
        start_run(4'd2);
        feed(4'd14);
        feed(4'd1);
        finish_run("t6", 4'd15, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
